icv_assembler: RTL and testbench

ICV_ASSEMBLER -- requirements
Module: icv_assembler

---
 rtl/icv_assembler_pkg.sv | 14 +
 rtl/icv_assembler_sec_timeout_cnt.sv | 30 +++
 rtl/icv_assembler.sv | 118 +++++++++++
 tb/tb_icv_assembler.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/icv_assembler_pkg.sv
// Shared definitions for the receive-side security blocks: ICV geometry and
// the assembler state encoding.
package icv_assembler_pkg;

    localparam int unsigned ICV_W  = 128;
    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_HOLD    = 2'd2
    } icv_state_e;

endpackage

// File: rtl/icv_assembler_sec_timeout_cnt.sv
// Saturating cycle counter for the ICV collection window; expired flags the
// last permitted cycle (count == TIMEOUT-1).
module sec_timeout_cnt #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clk,
    input  logic g_rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TW-1:0] count_q;

    assign expired = (count_q == TW'(TIMEOUT - 1));

    // Clear wins over enable; the counter holds once it reaches the limit.
    always_ff @(posedge clk or posedge g_rst) begin
        if (g_rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && !expired) begin
            count_q <= count_q + TW'(1);
        end
    end

endmodule

// File: rtl/icv_assembler.sv
// Collects the CMAC engine's ICV words (MS word first) into a 128-bit value,
// holding the result or a length/timeout fault until the frame is resolved.
module icv_assembler
    import icv_assembler_pkg::*;
#(
    parameter int unsigned ICV_WORDS = 4,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic              clk,
    input  logic              g_rst,
    input  logic              start,
    input  logic              abort,
    input  logic              rx_success,
    input  logic              word_valid,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_last,
    output logic              word_ready,
    output logic [ICV_W-1:0]  rcvd_dataout_combined,
    output logic              rcvd_done_combined,
    output logic              icv_err,
    output logic              busy
);

    localparam int unsigned CW = $clog2(ICV_WORDS) + 1;

    icv_state_e        state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [ICV_W-1:0]  data_q, data_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              ready_q;
    logic              busy_q;
    logic              xfer;
    logic              timer_clear;
    logic              timer_en;
    logic              timer_expired;

    assign xfer     = word_valid && (state_q == ST_COLLECT);
    assign timer_en = (state_q == ST_COLLECT);

    sec_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .g_rst   (g_rst),
        .clear   (timer_clear),
        .enable  (timer_en),
        .expired (timer_expired)
    );

    // Next-state: abort > rx_success > start > word transfer / timeout.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        data_d      = data_q;
        done_d      = 1'b0;
        err_d       = err_q;
        timer_clear = 1'b0;

        if (abort || (rx_success && (state_q != ST_IDLE))) begin
            state_d     = ST_IDLE;
            count_d     = '0;
            data_d      = '0;
            err_d       = 1'b0;
            timer_clear = 1'b1;
        end else if (start) begin
            state_d     = ST_COLLECT;
            count_d     = '0;
            data_d      = '0;
            err_d       = 1'b0;
            timer_clear = 1'b1;
        end else if (state_q == ST_COLLECT) begin
            if (xfer) begin
                for (int k = 0; k < int'(ICV_WORDS); k++) begin
                    if (count_q == CW'(k)) begin
                        data_d[ICV_W-1-WORD_W*k -: WORD_W] = word_data;
                    end
                end
                count_d = count_q + CW'(1);
            end
            // A completing transfer beats a timeout landing on the same cycle.
            if (xfer && (count_q == CW'(ICV_WORDS - 1))) begin
                state_d = ST_HOLD;
                done_d  = 1'b1;
            end else if ((xfer && word_last) || timer_expired) begin
                state_d = ST_HOLD;
                err_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge g_rst) begin
        if (g_rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ready_q <= (state_d == ST_COLLECT);
            busy_q  <= (state_d == ST_COLLECT);
        end
    end

    assign word_ready            = ready_q;
    assign busy                  = busy_q;
    assign rcvd_dataout_combined = data_q;
    assign rcvd_done_combined    = done_q;
    assign icv_err               = err_q;

endmodule

// File: tb/tb_icv_assembler.sv
// Directed bench for icv_assembler (ICV_WORDS=4, TIMEOUT=16).
module tb_icv_assembler;

    logic         clk;
    logic         g_rst;
    logic         start;
    logic         abort;
    logic         rx_success;
    logic         word_valid;
    logic [31:0]  word_data;
    logic         word_last;
    logic         word_ready;
    logic [127:0] rcvd_dataout_combined;
    logic         rcvd_done_combined;
    logic         icv_err;
    logic         busy;

    int tests_run = 0;
    int tests_failed = 0;

    icv_assembler #(
        .ICV_WORDS (4),
        .TIMEOUT   (16)
    ) dut (
        .clk                   (clk),
        .g_rst                 (g_rst),
        .start                 (start),
        .abort                 (abort),
        .rx_success            (rx_success),
        .word_valid            (word_valid),
        .word_data             (word_data),
        .word_last             (word_last),
        .word_ready            (word_ready),
        .rcvd_dataout_combined (rcvd_dataout_combined),
        .rcvd_done_combined    (rcvd_done_combined),
        .icv_err               (icv_err),
        .busy                  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start      = 1'b0;
        abort      = 1'b0;
        rx_success = 1'b0;
        word_valid = 1'b0;
        word_data  = '0;
        word_last  = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d, input logic last);
        idle_inputs();
        word_valid = 1'b1;
        word_data  = d;
        word_last  = last;
        tick();
    endtask

    task automatic do_start();
        idle_inputs();
        start = 1'b1;
        tick();
        idle_inputs();
    endtask

    task automatic do_rx_success();
        idle_inputs();
        rx_success = 1'b1;
        tick();
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        g_rst = 1'b1;
        tick();
        tick();
        check("reset_dataout", rcvd_dataout_combined, 128'h0);
        check("reset_done",    {127'h0, rcvd_done_combined}, 128'h0);
        check("reset_err",     {127'h0, icv_err}, 128'h0);
        check("reset_ready",   {127'h0, word_ready}, 128'h0);
        check("reset_busy",    {127'h0, busy}, 128'h0);
        g_rst = 1'b0;
        tick();

        // Words offered in IDLE are ignored
        send_word(32'hDEADBEEF, 1'b0);
        idle_inputs();
        check("idle_ready", {127'h0, word_ready}, 128'h0);
        check("idle_ignore_word", rcvd_dataout_combined, 128'h0);

        // Four back-to-back words
        do_start();
        check("start_ready", {127'h0, word_ready}, 128'h1);
        check("start_busy",  {127'h0, busy}, 128'h1);
        send_word(32'h11111111, 1'b0);
        send_word(32'h22222222, 1'b0);
        send_word(32'h33333333, 1'b0);
        check("no_early_done", {127'h0, rcvd_done_combined}, 128'h0);
        send_word(32'h44444444, 1'b1);
        idle_inputs();
        check("b2b_done", {127'h0, rcvd_done_combined}, 128'h1);
        check("b2b_data", rcvd_dataout_combined, 128'h11111111222222223333333344444444);
        check("b2b_err",  {127'h0, icv_err}, 128'h0);
        check("b2b_hold_ready", {127'h0, word_ready}, 128'h0);
        tick();
        check("b2b_done_single", {127'h0, rcvd_done_combined}, 128'h0);
        check("b2b_data_held", rcvd_dataout_combined, 128'h11111111222222223333333344444444);
        do_rx_success();
        check("rxs_data_clear", rcvd_dataout_combined, 128'h0);
        check("rxs_busy", {127'h0, busy}, 128'h0);

        // Early word_last: length fault
        do_start();
        send_word(32'hAAAAAAAA, 1'b0);
        send_word(32'hBBBBBBBB, 1'b1);
        idle_inputs();
        check("short_err",  {127'h0, icv_err}, 128'h1);
        check("short_done", {127'h0, rcvd_done_combined}, 128'h0);
        tick();
        tick();
        check("short_data_held", rcvd_dataout_combined, 128'hAAAAAAAABBBBBBBB0000000000000000);
        check("short_err_held",  {127'h0, icv_err}, 128'h1);
        check("short_ready", {127'h0, word_ready}, 128'h0);
        do_rx_success();
        check("short_clear_err",  {127'h0, icv_err}, 128'h0);
        check("short_clear_data", rcvd_dataout_combined, 128'h0);

        // Timeout: three words then silence; timer reaches 15 after 15 COLLECT cycles
        do_start();
        send_word(32'h01010101, 1'b0);
        send_word(32'h02020202, 1'b0);
        send_word(32'h03030303, 1'b0);
        idle_inputs();
        for (int i = 0; i < 12; i++) tick();
        check("to_not_yet_err",   {127'h0, icv_err}, 128'h0);
        check("to_not_yet_ready", {127'h0, word_ready}, 128'h1);
        tick();
        check("to_err",   {127'h0, icv_err}, 128'h1);
        check("to_ready", {127'h0, word_ready}, 128'h0);
        check("to_done",  {127'h0, rcvd_done_combined}, 128'h0);
        tick();
        check("to_ready_after", {127'h0, word_ready}, 128'h0);
        do_rx_success();

        // Completion on the timeout cycle wins
        do_start();
        for (int i = 0; i < 12; i++) tick();
        send_word(32'hC0000000, 1'b0);
        send_word(32'hC1111111, 1'b0);
        send_word(32'hC2222222, 1'b0);
        send_word(32'hC3333333, 1'b0);
        idle_inputs();
        check("edge_done", {127'h0, rcvd_done_combined}, 128'h1);
        check("edge_err",  {127'h0, icv_err}, 128'h0);
        check("edge_data", rcvd_dataout_combined, 128'hC0000000C1111111C2222222C3333333);
        do_rx_success();

        // Abort on the final transfer suppresses done
        do_start();
        send_word(32'h55555555, 1'b0);
        send_word(32'h66666666, 1'b0);
        send_word(32'h77777777, 1'b0);
        idle_inputs();
        abort      = 1'b1;
        word_valid = 1'b1;
        word_data  = 32'h88888888;
        tick();
        idle_inputs();
        check("abort_done",  {127'h0, rcvd_done_combined}, 128'h0);
        check("abort_data",  rcvd_dataout_combined, 128'h0);
        check("abort_busy",  {127'h0, busy}, 128'h0);
        check("abort_ready", {127'h0, word_ready}, 128'h0);
        tick();
        check("abort_done_after", {127'h0, rcvd_done_combined}, 128'h0);

        // Async reset mid-collection
        do_start();
        send_word(32'h99999999, 1'b0);
        send_word(32'h9A9A9A9A, 1'b0);
        g_rst = 1'b1;
        #1;
        check("grst_async_data", rcvd_dataout_combined, 128'h0);
        check("grst_async_busy", {127'h0, busy}, 128'h0);
        tick();
        g_rst = 1'b0;
        tick();
        check("grst_no_done", {127'h0, rcvd_done_combined}, 128'h0);
        do_start();
        send_word(32'hA0A0A0A0, 1'b0);
        send_word(32'hB1B1B1B1, 1'b0);
        send_word(32'hC2C2C2C2, 1'b0);
        send_word(32'hD3D3D3D3, 1'b0);
        idle_inputs();
        check("grst_new_done", {127'h0, rcvd_done_combined}, 128'h1);
        check("grst_new_data", rcvd_dataout_combined, 128'hA0A0A0A0B1B1B1B1C2C2C2C2D3D3D3D3);
        tick();
        check("grst_done_single", {127'h0, rcvd_done_combined}, 128'h0);

        // Start in HOLD restarts collection
        do_start();
        check("restart_data_clear", rcvd_dataout_combined, 128'h0);
        check("restart_busy", {127'h0, busy}, 128'h1);
        send_word(32'h0F0F0F0F, 1'b0);
        send_word(32'hF0F0F0F0, 1'b0);
        send_word(32'h12345678, 1'b0);
        send_word(32'h9ABCDEF0, 1'b0);
        idle_inputs();
        check("restart_done", {127'h0, rcvd_done_combined}, 128'h1);
        check("restart_data", rcvd_dataout_combined, 128'h0F0F0F0FF0F0F0F0123456789ABCDEF0);
        check("restart_err",  {127'h0, icv_err}, 128'h0);

        // rx_success beats start in HOLD
        idle_inputs();
        rx_success = 1'b1;
        start      = 1'b1;
        tick();
        idle_inputs();
        check("prio_rxs_busy", {127'h0, busy}, 128'h0);
        check("prio_rxs_data", rcvd_dataout_combined, 128'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
